all1_sched: RTL and testbench
=============================

ALL1_SCHED -- requirements
Module: all1_sched

Interface
- REQ-001: Parameter SETTLE, default 1, cycles dp_x is held before dp_out is sampled; legal range 1..15.
- REQ-002: Parameter CNT_W, default 8, width of the hit_cnt statistics counter.
- REQ-003: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: req  input  4  per-requester level request; req[i] belongs to requester i.
- REQ-006: pat  input  16  per-requester patterns; pat[4i+3:4i] is requester i's {x1,x2,x3,x4}.
- REQ-007: dp_x  output  4  pattern to the shared all1 datapath; dp_x[3]=x1, dp_x[2]=x2, dp_x[1]=x3, dp_x[0]=x4.
- REQ-008: dp_out  input  1  combinational result from the all1 datapath.
- REQ-009: gnt  output  4  one-hot grant; at most one bit high.
- REQ-010: rsp_valid  output  1  one-cycle pulse; result is available.
- REQ-011: rsp_id  output  2  index of the requester owning the response.
- REQ-012: rsp_result  output  1  sampled dp_out for rsp_id.
- REQ-013: busy  output  1  high in every state except IDLE.
- REQ-014: hit_cnt  output  CNT_W  saturating count of responses with rsp_result=1.

Function
- REQ-015: FSM states are IDLE, DRIVE, SAMPLE and RESP; all outputs are registered.
- REQ-016: In IDLE with req!=0, the block selects a winner round-robin, starting at ptr and searching ptr, ptr+1, ... mod 4; next state is DRIVE.
- REQ-017: On entry to DRIVE, the block loads dp_x from the winner's pat slice, sets gnt to the winner's one-hot, loads settle counter = SETTLE-1 and sets ptr = winner+1 mod 4.
- REQ-018: The block stays in DRIVE while the settle counter != 0, decrementing it each cycle, then goes to SAMPLE; dp_x and gnt hold stable throughout.
- REQ-019: In SAMPLE the block captures dp_out into rsp_result and goes to RESP.
- REQ-020: In RESP, rsp_valid=1 and rsp_id=winner for exactly one cycle; gnt is cleared and dp_x holds; next state is IDLE.
- REQ-021: Latency with SETTLE=1: req seen in IDLE at cycle N, gnt high at N+1, sample at N+2, rsp_valid at N+3; back-to-back service restarts from IDLE at N+4, giving 4 cycles per transaction.
- REQ-022: Requester i holds req[i] and pat[i] stable from assertion until it sees rsp_valid with rsp_id=i; the block ignores req changes outside IDLE.
- REQ-023: If req[i] drops while i is granted, the transaction still completes and the response is issued.
- REQ-024: With all four requesting continuously, service order is 0,1,2,3,0,... with no starvation; a single requester is served on every transaction.
- REQ-025: hit_cnt increments by 1 in the RESP cycle when rsp_result=1 and saturates at 2^CNT_W-1; it never wraps.
- REQ-026: dp_x changes only on entry to DRIVE.

Reset
- REQ-027: rst high at a clock edge forces state=IDLE, gnt=0, dp_x=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, hit_cnt=0 and ptr=0.
- REQ-028: rst asserted mid-transaction aborts it with no response issued.
- REQ-029: After rst deasserts, the first grant follows REQ-016 with ptr=0.

Verification
- REQ-030: Single requester: req=0001, pat[3:0]=0001, all1 datapath attached -> gnt=0001 one cycle after req, then rsp_valid with rsp_id=0, rsp_result=1 three cycles after req, hit_cnt=1.
- REQ-031: Requester 1 alone with pat=0111 -> rsp_id=1, rsp_result=0, hit_cnt unchanged.
- REQ-032: req=1111 held, patterns 1000/0101/0010/0110 for requesters 0..3 -> responses in id order 0,1,2,3 with results 1,0,1,0, one every 4 cycles.
- REQ-033: SETTLE=3, single request -> dp_x stable for 3 cycles, rsp_valid 5 cycles after req.
- REQ-034: CNT_W=2, six responses all with result 1 -> hit_cnt reads 1,2,3,3,3,3.
- REQ-035: rst pulsed during DRIVE -> no rsp_valid, all outputs 0, next grant goes to the lowest-index requester.

Source files
------------

// File: rtl/all1_sched.sv
// Round-robin scheduler sharing one all1 datapath among four requesters.
// Each grant drives the winner's pattern, waits SETTLE cycles, samples dp_out and pulses a response.
module all1_sched #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [15:0]      pat,
    output logic [3:0]       dp_x,
    input  logic             dp_out,
    output logic [3:0]       gnt,
    output logic             rsp_valid,
    output logic [1:0]       rsp_id,
    output logic             rsp_result,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt
);

    // state  | meaning
    // IDLE   | waiting for any request; arbitration happens here
    // DRIVE  | winner's pattern on dp_x, settle counter running down
    // SAMPLE | dp_out has settled; captured at the end of this cycle
    // RESP   | rsp_valid pulse, grant already dropped
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] HIT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HIT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       win_q, win_d;
    logic [3:0]       settle_q, settle_d;
    logic [3:0]       dp_x_q, dp_x_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_id_q, rsp_id_d;
    logic             rsp_result_q, rsp_result_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    // Search ptr, ptr+1, ... so the requester after the last winner has priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        settle_d     = settle_q;
        dp_x_d       = dp_x_q;
        gnt_d        = gnt_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        hit_cnt_d    = hit_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = DRIVE;
                    win_d    = win_idx;
                    ptr_d    = win_idx + 2'd1;
                    dp_x_d   = pat[{win_idx, 2'b00} +: 4];
                    gnt_d    = 4'b0001 << win_idx;
                    settle_d = SETTLE_LOAD;
                end
            end
            DRIVE: begin
                if (settle_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            SAMPLE: begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_id_d     = win_q;
                rsp_result_d = dp_out;
                gnt_d        = 4'b0000;
                if (dp_out && (hit_cnt_q != HIT_MAX)) begin
                    hit_cnt_d = hit_cnt_q + HIT_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd0;
            win_q        <= 2'd0;
            settle_q     <= 4'd0;
            dp_x_q       <= 4'd0;
            gnt_q        <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 2'd0;
            rsp_result_q <= 1'b0;
            busy_q       <= 1'b0;
            hit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            settle_q     <= settle_d;
            dp_x_q       <= dp_x_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            busy_q       <= busy_d;
            hit_cnt_q    <= hit_cnt_d;
        end
    end

    assign dp_x       = dp_x_q;
    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;
    assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_all1_sched.sv
// Bench for all1_sched: vector table, directed corner sequences and a random run
// against a transaction-level reference. The attached datapath is true for exactly one set bit.
module tb_all1_sched;

    localparam int SETTLE_D = 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst3;
    logic [3:0]  req, req3;
    logic [15:0] pat, pat3;
    logic [3:0]  dp_x, dp_x3;
    logic        dp_out, dp_out3;
    logic [3:0]  gnt, gnt3;
    logic        rsp_valid, rsp_valid3;
    logic [1:0]  rsp_id, rsp_id3;
    logic        rsp_result, rsp_result3;
    logic        busy, busy3;
    logic [7:0]  hit_cnt;
    logic [1:0]  hit_cnt3;

    int total = 0;
    int bad   = 0;

    function automatic logic all1(input logic [3:0] x);
        return ($countones(x) == 1);
    endfunction

    assign dp_out  = all1(dp_x);
    assign dp_out3 = all1(dp_x3);

    all1_sched u_dut (
        .clk(clk), .rst(rst), .req(req), .pat(pat), .dp_x(dp_x), .dp_out(dp_out),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy), .hit_cnt(hit_cnt)
    );

    all1_sched #(.SETTLE(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst3), .req(req3), .pat(pat3), .dp_x(dp_x3), .dp_out(dp_out3),
        .gnt(gnt3), .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_result(rsp_result3),
        .busy(busy3), .hit_cnt(hit_cnt3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        req = 4'd0;
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] pat;
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic        res;
        logic [7:0]  hits;
    } vec_t;

    vec_t vt[7];

    // reference model state for the random run
    bit         m_active;
    int         m_k, m_w, m_ptr, m_hits;
    logic [3:0] m_dpx;
    bit         m_res;
    bit [3:0]   seen_rsp;

    int         n_rsp;
    int         r_id[8];
    int         r_res[8];
    int         r_cyc[8];
    int         got;

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        req = 4'd0; req3 = 4'd0;
        pat = 16'd0; pat3 = 16'd0;
        tick(); tick();

        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_dp_x", 32'(dp_x), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst3_busy", 32'(busy3), 32'd0);
        chk("rst3_hit_cnt", 32'(hit_cnt3), 32'd0);
        @(negedge clk);
        rst = 1'b0; rst3 = 1'b0;

        // pointer walks 0 -> 1 -> 2 -> 0 -> 1 -> 3 -> 1 -> 2 across these vectors
        vt[0] = '{req: 4'b0001, pat: 16'h0001, gnt: 4'b0001, id: 2'd0, res: 1'b1, hits: 8'd1};
        vt[1] = '{req: 4'b0010, pat: 16'h0070, gnt: 4'b0010, id: 2'd1, res: 1'b0, hits: 8'd1};
        vt[2] = '{req: 4'b1001, pat: 16'h8003, gnt: 4'b1000, id: 2'd3, res: 1'b1, hits: 8'd2};
        vt[3] = '{req: 4'b1001, pat: 16'h8000, gnt: 4'b0001, id: 2'd0, res: 1'b0, hits: 8'd2};
        vt[4] = '{req: 4'b0101, pat: 16'h0401, gnt: 4'b0100, id: 2'd2, res: 1'b1, hits: 8'd3};
        vt[5] = '{req: 4'b0001, pat: 16'h000F, gnt: 4'b0001, id: 2'd0, res: 1'b0, hits: 8'd3};
        vt[6] = '{req: 4'b0110, pat: 16'h0F20, gnt: 4'b0010, id: 2'd1, res: 1'b1, hits: 8'd4};

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            req = vt[v].req;
            pat = vt[v].pat;
            tick();
            chk("vec_gnt", 32'(gnt), 32'(vt[v].gnt));
            chk("vec_dp_x", 32'(dp_x), 32'((vt[v].pat >> (4 * int'(vt[v].id))) & 16'hF));
            chk("vec_busy", 32'(busy), 32'd1);
            tick();
            chk("vec_gnt_sample", 32'(gnt), 32'(vt[v].gnt));
            chk("vec_early_valid", 32'(rsp_valid), 32'd0);
            tick();
            chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("vec_rsp_id", 32'(rsp_id), 32'(vt[v].id));
            chk("vec_rsp_result", 32'(rsp_result), 32'(vt[v].res));
            chk("vec_gnt_resp", 32'(gnt), 32'd0);
            @(negedge clk);
            req = 4'd0;
            tick();
            chk("vec_idle_busy", 32'(busy), 32'd0);
            chk("vec_idle_valid", 32'(rsp_valid), 32'd0);
            chk("vec_hit_cnt", 32'(hit_cnt), 32'(vt[v].hits));
        end

        // all four held: fair rotation, one response every 4 cycles
        reset_dut();
        req = 4'b1111;
        pat = 16'h6258;
        n_rsp = 0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (rsp_valid && n_rsp < 8) begin
                r_id[n_rsp]  = int'(rsp_id);
                r_res[n_rsp] = int'(rsp_result);
                r_cyc[n_rsp] = c;
                n_rsp++;
            end
        end
        chk("rr_count", 32'(n_rsp), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_id", 32'(r_id[i]), 32'(i));
            chk("rr_result", 32'(r_res[i]), ((i % 2) == 0) ? 32'd1 : 32'd0);
            chk("rr_cycle", 32'(r_cyc[i]), 32'(3 + 4 * i));
        end
        @(negedge clk);
        req = 4'd0;
        for (int c = 0; c < 4; c++) tick();
        chk("rr_hit_cnt", 32'(hit_cnt), 32'd3);
        chk("rr_drained", 32'(busy), 32'd0);

        // request withdrawn while granted still completes
        @(negedge clk);
        req = 4'b0100;
        pat = 16'h0100;
        tick();
        chk("drop_gnt", 32'(gnt), 32'b0100);
        @(negedge clk);
        req = 4'd0;
        tick();
        tick();
        chk("drop_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("drop_rsp_id", 32'(rsp_id), 32'd2);
        chk("drop_rsp_result", 32'(rsp_result), 32'd1);
        tick();
        chk("drop_hit_cnt", 32'(hit_cnt), 32'd4);

        // reset in DRIVE aborts the transaction and rewinds the pointer
        @(negedge clk);
        req = 4'b0100;
        pat = 16'h0100;
        tick();
        chk("abort_gnt", 32'(gnt), 32'b0100);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("abort_gnt0", 32'(gnt), 32'd0);
        chk("abort_dp_x0", 32'(dp_x), 32'd0);
        chk("abort_valid0", 32'(rsp_valid), 32'd0);
        chk("abort_id0", 32'(rsp_id), 32'd0);
        chk("abort_result0", 32'(rsp_result), 32'd0);
        chk("abort_busy0", 32'(busy), 32'd0);
        chk("abort_hit0", 32'(hit_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end
        @(negedge clk);
        req = 4'b1010;
        pat = 16'h0000;
        tick();
        chk("abort_next_gnt", 32'(gnt), 32'b0010);
        @(negedge clk);
        req = 4'd0;
        for (int c = 0; c < 4; c++) tick();

        // SETTLE=3: three DRIVE cycles, response five cycles after the request edge
        @(negedge clk);
        req3 = 4'b0001;
        pat3 = 16'h0002;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("s3_gnt", 32'(gnt3), 32'b0001);
            chk("s3_dp_x", 32'(dp_x3), 32'h2);
            chk("s3_no_valid", 32'(rsp_valid3), 32'd0);
        end
        tick();
        chk("s3_rsp_valid", 32'(rsp_valid3), 32'd1);
        chk("s3_rsp_id", 32'(rsp_id3), 32'd0);
        chk("s3_rsp_result", 32'(rsp_result3), 32'd1);
        chk("s3_dp_x_hold", 32'(dp_x3), 32'h2);
        @(negedge clk);
        req3 = 4'd0;
        tick();
        chk("s3_busy_end", 32'(busy3), 32'd0);
        chk("s3_hit_cnt", 32'(hit_cnt3), 32'd1);

        // CNT_W=2 saturation
        @(negedge clk);
        rst3 = 1'b1;
        tick();
        @(negedge clk);
        rst3 = 1'b0;
        pat3 = 16'h4444;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req3 = 4'b0001 << (k % 4);
            got = 0;
            for (int c = 0; c < 10 && got == 0; c++) begin
                tick();
                if (rsp_valid3) got = 1;
            end
            chk("sat_rsp_seen", 32'(got), 32'd1);
            chk("sat_rsp_id", 32'(rsp_id3), 32'(k % 4));
            @(negedge clk);
            req3 = 4'd0;
            tick();
            chk("sat_hit_cnt", 32'(hit_cnt3), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
        end

        // random traffic against a transaction-level reference
        reset_dut();
        m_active = 0; m_k = 0; m_w = 0; m_ptr = 0; m_hits = 0; m_dpx = 4'd0; m_res = 0;
        seen_rsp = 4'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (seen_rsp[i]) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    pat[4*i +: 4] = 4'($urandom_range(0, 15));
                end else begin
                    pat[4*i +: 4] = 4'($urandom_range(0, 15));
                end
            end
            seen_rsp = 4'd0;

            if (m_active) begin
                m_k++;
                if (m_k == SETTLE_D + 2) begin
                    m_res = all1(m_dpx);
                    if (m_res && m_hits < 255) m_hits++;
                end else if (m_k > SETTLE_D + 2) begin
                    m_active = 0;
                end
            end else if (req != 4'd0) begin
                for (int s = 0; s < 4; s++) begin
                    if (req[(m_ptr + s) % 4]) begin
                        m_w = (m_ptr + s) % 4;
                        break;
                    end
                end
                m_active = 1;
                m_k      = 1;
                m_dpx    = 4'((pat >> (4 * m_w)) & 16'hF);
                m_ptr    = (m_w + 1) % 4;
            end

            tick();
            chk("rnd_gnt", 32'(gnt), (m_active && m_k <= SETTLE_D + 1) ? (32'd1 << m_w) : 32'd0);
            chk("rnd_busy", 32'(busy), 32'(m_active));
            chk("rnd_dp_x", 32'(dp_x), 32'(m_dpx));
            chk("rnd_hit_cnt", 32'(hit_cnt), 32'(m_hits));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_active && m_k == SETTLE_D + 2));
            if (m_active && m_k == SETTLE_D + 2) begin
                chk("rnd_rsp_id", 32'(rsp_id), 32'(m_w));
                chk("rnd_rsp_result", 32'(rsp_result), 32'(m_res));
                seen_rsp[m_w] = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
